if_sequencer: RTL and testbench

Control sequencer for the instruction-fetch stage. It arbitrates between pipeline stall, branch redirect, exception entry and exception return, and it drives the fetch stage's hold, PC-source and flush controls. It also owns the EPC, cause and exception-level (EXL) registers. It sits between the ID/EX hazard logic and the IF stage, and it absorbs the one-cycle latency of the synchronous instruction ROM by flushing wrong-path fetches.

---
 rtl/if_sequencer_if.sv | 28 ++
 rtl/if_sequencer.sv | 72 +++++++
 tb/tb_if_sequencer.sv | 99 +++++++++
 3 files changed

// File: rtl/if_sequencer_if.sv
// if_sequencer_if: fetch-control bundle between the hazard/EX logic (master) and the IF sequencer (slave).
interface if_sequencer_if;
    logic        load_use;
    logic        br_taken;
    logic [31:0] br_target;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        eret;
    logic        hold_pc;
    logic        hold_if;
    logic        br;
    logic        except;
    logic [31:0] pc_branch;
    logic        flush_if;
    logic        flush_ex;
    logic [31:0] epc;
    logic [4:0]  cause;
    logic        exl;
    modport master (
        output load_use, br_taken, br_target, exc_req, exc_code, exc_pc, eret,
        input  hold_pc, hold_if, br, except, pc_branch, flush_if, flush_ex, epc, cause, exl
    );
    modport slave (
        input  load_use, br_taken, br_target, exc_req, exc_code, exc_pc, eret,
        output hold_pc, hold_if, br, except, pc_branch, flush_if, flush_ex, epc, cause, exl
    );
endinterface

// File: rtl/if_sequencer.sv
// if_sequencer: IF-stage control sequencer arbitrating stall, branch, exception entry and eret; owns EPC/cause/EXL.
module if_sequencer #(
    parameter int BOOT_CYCLES  = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input logic           clk,
    input logic           rst_n,
    if_sequencer_if.slave bus
);
    typedef enum logic [2:0] {BOOT, RUN, STALL, REDIRECT, EXC} state_t;
    localparam logic [2:0] BOOT_N  = 3'(BOOT_CYCLES);
    localparam logic [2:0] FLUSH_N = 3'(FLUSH_CYCLES);
    state_t     state;
    logic [2:0] cnt;
    logic       arb, flushing, flush_done, go_exc, go_br, go_eret, go_stall, go_any;
    assign arb        = state == RUN || state == STALL;
    assign flushing   = state == REDIRECT || state == EXC;
    assign flush_done = cnt >= FLUSH_N;
    // an exception may abandon a redirect in progress, but never re-enters while exl is set
    assign go_exc   = (arb || state == REDIRECT) && bus.exc_req && !bus.exl;
    assign go_br    = arb && !go_exc && bus.br_taken;
    assign go_eret  = arb && !go_exc && !bus.br_taken && bus.eret && bus.exl;
    assign go_stall = arb && !go_exc && !go_br && !go_eret && bus.load_use;
    assign go_any   = go_exc || go_br || go_eret;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= BOOT;
            cnt           <= '0;
            bus.hold_pc   <= 1'b1;
            bus.hold_if   <= 1'b1;
            bus.br        <= 1'b0;
            bus.except    <= 1'b0;
            bus.pc_branch <= '0;
            bus.flush_if  <= 1'b0;
            bus.flush_ex  <= 1'b0;
            bus.epc       <= '0;
            bus.cause     <= '0;
            bus.exl       <= 1'b0;
        end else begin
            bus.hold_pc  <= state == BOOT ? cnt < BOOT_N : go_stall;
            bus.hold_if  <= state == BOOT ? cnt < BOOT_N : go_stall;
            bus.br       <= go_br || go_eret;
            bus.except   <= go_exc;
            bus.flush_ex <= go_exc;
            bus.flush_if <= go_any || (flushing && !flush_done);
            if (go_br || go_eret)
                bus.pc_branch <= go_br ? bus.br_target : bus.epc;
            if (go_exc) begin
                bus.epc   <= bus.exc_pc;
                bus.cause <= bus.exc_code;
                bus.exl   <= 1'b1;
            end else if (go_eret)
                bus.exl <= 1'b0;
            if (go_any) begin
                state <= go_exc ? EXC : REDIRECT;
                cnt   <= 3'd1;
            end else begin
                case (state)
                    BOOT: begin
                        if (cnt >= BOOT_N) state <= RUN;
                        else cnt <= cnt + 3'd1;
                    end
                    RUN, STALL: state <= go_stall ? STALL : RUN;
                    default: begin
                        if (flush_done) state <= RUN;
                        else cnt <= cnt + 3'd1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_if_sequencer.sv
// tb_if_sequencer: table-driven, scoreboarded check of the IF sequencer control outputs.
module tb_if_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    if_sequencer_if bus();
    if_sequencer #(.BOOT_CYCLES(2), .FLUSH_CYCLES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    typedef struct packed {
        logic        hp, hi, br, ex;
        logic [31:0] pcb;
        logic        fi, fe;
        logic [31:0] epc;
        logic [4:0]  cause;
        logic        exl;
    } out_t;
    typedef struct {
        logic        rst_n, lu, bt;
        logic [31:0] tgt;
        logic        er;
        logic [4:0]  code;
        logic [31:0] pc;
        logic        eret;
        out_t        exp;
    } vec_t;
    out_t sb[$];
    int   tests = 0;
    int   failed = 0;
    vec_t tbl[19];
    function automatic vec_t v(input logic r, lu, bt, input logic [31:0] tgt, input logic er,
                               input logic [4:0] code, input logic [31:0] pc, input logic eret,
                               input logic h, br, ex, input logic [31:0] pcb, input logic fi, fe,
                               input logic [31:0] epc, input logic [4:0] cause, input logic exl);
        vec_t t;
        t.rst_n = r; t.lu = lu; t.bt = bt; t.tgt = tgt; t.er = er; t.code = code; t.pc = pc; t.eret = eret;
        t.exp = '{hp: h, hi: h, br: br, ex: ex, pcb: pcb, fi: fi, fe: fe, epc: epc, cause: cause, exl: exl};
        return t;
    endfunction
    task automatic check(input string name);
        out_t e, a;
        e = sb.pop_front();
        a = {bus.hold_pc, bus.hold_if, bus.br, bus.except, bus.pc_branch, bus.flush_if, bus.flush_ex,
             bus.epc, bus.cause, bus.exl};
        tests++;
        if (a !== e) begin
            failed++;
            $display("FAIL %s: got %h expected %h (hp hi br ex pcb fi fe epc cause exl)", name, a, e);
        end
    endtask
    task automatic step(input vec_t t, input string name);
        @(negedge clk);
        rst_n = t.rst_n;
        bus.load_use = t.lu; bus.br_taken = t.bt; bus.br_target = t.tgt;
        bus.exc_req = t.er; bus.exc_code = t.code; bus.exc_pc = t.pc; bus.eret = t.eret;
        sb.push_back(t.exp);
        @(posedge clk);
        #1;
        check(name);
    endtask
    initial begin
        bus.load_use = 0; bus.br_taken = 0; bus.br_target = 0; bus.exc_req = 0;
        bus.exc_code = 0; bus.exc_pc = 0; bus.eret = 0;
        tbl[0]  = v(0,0,0,0,    0,0,0,0,      1,0,0,0,    0,0,0,0,0);
        tbl[1]  = v(1,0,1,'h99, 0,0,0,0,      1,0,0,0,    0,0,0,0,0);
        tbl[2]  = v(1,0,0,0,    0,0,0,0,      1,0,0,0,    0,0,0,0,0);
        tbl[3]  = v(1,0,0,0,    0,0,0,0,      0,0,0,0,    0,0,0,0,0);
        tbl[4]  = v(1,1,0,0,    0,0,0,0,      1,0,0,0,    0,0,0,0,0);
        tbl[5]  = v(1,1,0,0,    0,0,0,0,      1,0,0,0,    0,0,0,0,0);
        tbl[6]  = v(1,1,0,0,    0,0,0,0,      1,0,0,0,    0,0,0,0,0);
        tbl[7]  = v(1,0,0,0,    0,0,0,0,      0,0,0,0,    0,0,0,0,0);
        tbl[8]  = v(1,0,1,'h20, 0,0,0,0,      0,1,0,'h20, 1,0,0,0,0);
        tbl[9]  = v(1,0,1,'h40, 0,0,0,0,      0,0,0,'h20, 1,0,0,0,0);
        tbl[10] = v(1,0,0,0,    0,0,0,0,      0,0,0,'h20, 0,0,0,0,0);
        tbl[11] = v(1,0,1,'h80, 1,12,'h14,0,  0,0,1,'h20, 1,1,'h14,12,1);
        tbl[12] = v(1,0,0,0,    0,0,0,0,      0,0,0,'h20, 1,0,'h14,12,1);
        tbl[13] = v(1,0,0,0,    0,0,0,0,      0,0,0,'h20, 0,0,'h14,12,1);
        tbl[14] = v(1,0,0,0,    1,3,'h50,0,   0,0,0,'h20, 0,0,'h14,12,1);
        tbl[15] = v(1,0,0,0,    0,0,0,1,      0,1,0,'h14, 1,0,'h14,12,0);
        tbl[16] = v(1,0,0,0,    0,0,0,0,      0,0,0,'h14, 1,0,'h14,12,0);
        tbl[17] = v(1,0,0,0,    0,0,0,0,      0,0,0,'h14, 0,0,'h14,12,0);
        tbl[18] = v(1,0,0,0,    0,0,0,1,      0,0,0,'h14, 0,0,'h14,12,0);
        for (int i = 0; i < 19; i++) step(tbl[i], $sformatf("vec%0d", i));
        // stall preempted by a branch; load_use is wrong-path during the flush
        step(v(1,1,0,0,      0,0,0,0,     1,0,0,'h14,  0,0,'h14,12,0), "stall_start");
        step(v(1,1,1,'h100,  0,0,0,0,     0,1,0,'h100, 1,0,'h14,12,0), "stall_preempt");
        step(v(1,1,0,0,      0,0,0,0,     0,0,0,'h100, 1,0,'h14,12,0), "redir_lu_ign1");
        step(v(1,1,0,0,      0,0,0,0,     0,0,0,'h100, 0,0,'h14,12,0), "redir_lu_ign2");
        step(v(1,0,0,0,      0,0,0,0,     0,0,0,'h100, 0,0,'h14,12,0), "run_idle");
        // exception abandons a redirect, then reset in the 2nd EXC cycle
        step(v(1,0,1,'h200,  0,0,0,0,     0,1,0,'h200, 1,0,'h14,12,0), "redir2");
        step(v(1,0,0,0,      1,7,'h30,0,  0,0,1,'h200, 1,1,'h30,7,1),  "exc_preempt");
        step(v(1,0,0,0,      0,0,0,0,     0,0,0,'h200, 1,0,'h30,7,1),  "exc_cyc2");
        step(v(0,0,0,0,      0,0,0,0,     1,0,0,0,     0,0,0,0,0),     "reset_mid_exc");
        step(v(1,0,0,0,      0,0,0,0,     1,0,0,0,     0,0,0,0,0),     "reboot1");
        step(v(1,0,0,0,      0,0,0,0,     1,0,0,0,     0,0,0,0,0),     "reboot2");
        step(v(1,0,0,0,      0,0,0,0,     0,0,0,0,     0,0,0,0,0),     "reboot_done");
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
